fadd_rr_scheduler: RTL

- Shares one FP16 adder pipeline (fixed latency, fully pipelined, no backpressure) between N_REQ requesters.
- Round-robin arbitration; at most one operand pair issued per cycle.
- Tracks each in-flight operation with an ID tag pipeline matched to the adder latency, and routes each result back to its issuing requester.
- Sits between requester engines and the adder instance. Never relies on the adder's result valid for timing, because the adder drops that valid on Inf/NaN.

---
 rtl/fadd_rr_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fadd_rr_scheduler.sv
// Round-robin front end that shares one fixed-latency FP16 adder between N_REQ requesters.
// A tag pipeline matched to the adder latency routes each result back to its issuer.
module fadd_rr_scheduler #(
  parameter int N_REQ   = 4,
  parameter int ADD_LAT = 6,
  parameter int MAX_OUT = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 cfg_en,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [16*N_REQ-1:0]  req_a,
  input  logic [16*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [15:0]          rsp_data,
  output logic                 rsp_exc,
  output logic                 busy,
  output logic [15:0]          fadd_a_tdata,
  output logic [15:0]          fadd_b_tdata,
  output logic                 fadd_a_tvalid,
  output logic                 fadd_b_tvalid,
  input  logic [15:0]          fadd_result_tdata,
  input  logic                 fadd_result_tvalid
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(MAX_OUT + 1);

  logic [IDW-1:0]   ptr_reg;
  logic [CW-1:0]    cnt_reg [N_REQ];
  logic [ADD_LAT:0] tag_v_reg;
  logic [IDW-1:0]   tag_id_reg [ADD_LAT+1];
  logic [N_REQ-1:0] rsp_valid_reg;
  logic [15:0]      rsp_data_reg;
  logic             rsp_exc_reg;
  logic [15:0]      fadd_a_reg;
  logic [15:0]      fadd_b_reg;
  logic             fadd_v_reg;
  logic             busy_reg;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] retire;
  logic [N_REQ-1:0] cnt_nz;
  logic [IDW-1:0]   cand_id [N_REQ];
  logic [IDW-1:0]   grant_id;
  logic             found;

  // cand_id[k] is the k-th requester in priority order, starting just after the last winner.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      logic [IDW:0] sum;
      assign sum          = {1'b0, ptr_reg} + (IDW+1)'(gi + 1);
      assign cand_id[gi]  = (sum >= (IDW+1)'(N_REQ)) ? IDW'(sum - (IDW+1)'(N_REQ)) : sum[IDW-1:0];
      assign eligible[gi] = aresetn & cfg_en & req_valid[gi] & (cnt_reg[gi] != CW'(MAX_OUT));
      assign retire[gi]   = tag_v_reg[ADD_LAT] & (tag_id_reg[ADD_LAT] == IDW'(gi));
      assign cnt_nz[gi]   = (cnt_reg[gi] != '0);
    end
  endgenerate

  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && eligible[cand_id[k]]) begin
        found    = 1'b1;
        grant_id = cand_id[k];
      end
    end
    grant = '0;
    if (found) grant[grant_id] = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr_reg       <= IDW'(N_REQ - 1);
      tag_v_reg     <= '0;
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
      rsp_exc_reg   <= 1'b0;
      fadd_a_reg    <= '0;
      fadd_b_reg    <= '0;
      fadd_v_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      for (int i = 0; i < N_REQ; i++) cnt_reg[i] <= '0;
      for (int s = 0; s <= ADD_LAT; s++) tag_id_reg[s] <= '0;
    end else begin
      if (found) begin
        ptr_reg    <= grant_id;
        fadd_a_reg <= req_a[16*grant_id +: 16];
        fadd_b_reg <= req_b[16*grant_id +: 16];
        fadd_v_reg <= 1'b1;
      end else begin
        fadd_a_reg <= '0;
        fadd_b_reg <= '0;
        fadd_v_reg <= 1'b0;
      end

      tag_v_reg     <= {tag_v_reg[ADD_LAT-1:0], found};
      tag_id_reg[0] <= grant_id;
      for (int s = 1; s <= ADD_LAT; s++) tag_id_reg[s] <= tag_id_reg[s-1];

      // The adder's own valid is only an exception flag here; timing comes from the tags.
      rsp_valid_reg <= retire;
      if (tag_v_reg[ADD_LAT]) begin
        rsp_data_reg <= fadd_result_tdata;
        rsp_exc_reg  <= ~fadd_result_tvalid;
      end

      for (int i = 0; i < N_REQ; i++) begin
        assert (!(grant[i] && !retire[i] && (cnt_reg[i] == CW'(MAX_OUT))));
        assert (!(retire[i] && !grant[i] && (cnt_reg[i] == '0)));
        if (grant[i] && !retire[i]) cnt_reg[i] <= cnt_reg[i] + CW'(1);
        else if (retire[i] && !grant[i]) cnt_reg[i] <= cnt_reg[i] - CW'(1);
      end

      busy_reg <= (|tag_v_reg) | (|cnt_nz);
    end
  end

  assign req_ready     = grant;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_data      = rsp_data_reg;
  assign rsp_exc       = rsp_exc_reg;
  assign busy          = busy_reg;
  assign fadd_a_tdata  = fadd_a_reg;
  assign fadd_b_tdata  = fadd_b_reg;
  assign fadd_a_tvalid = fadd_v_reg;
  assign fadd_b_tvalid = fadd_v_reg;

endmodule
